// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: glyph patterns (active-low, bit0=a .. bit6=g),
// the blank pattern and the number of digit slots.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Entry i holds the glyph for nibble value i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-low segment pattern back to its hex nibble; anything that is not one of the
// 16 hex glyphs (blank included) is flagged illegal and returns nibble 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       illegal_o
);

  always_comb begin
    nibble_o  = 4'h0;
    illegal_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == GLYPH_TABLE[i]) begin
        nibble_o  = 4'(i);
        illegal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_frame_capture.sv
// Samples a multiplexed 7-segment bus, accepts each digit once it is stable for STABLE_CYCLES
// edges, and presents every completed 4-digit frame on a valid/ready port with overrun tracking.
module seg7_frame_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_en_i,
  output logic [4*NUM_DIGITS-1:0] out_value_o,
  output logic [NUM_DIGITS-1:0]   out_err_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    overrun_o,
  input  logic                    ovr_clr_i
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [10:0] prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        acc_q, acc_d;
  logic [3:0]  cap_q, cap_d;
  logic [15:0] slot_val_q, slot_val_d;
  logic [3:0]  slot_err_q, slot_err_d;
  logic [15:0] out_value_q, out_value_d;
  logic [3:0]  out_err_q, out_err_d;
  logic        out_valid_q, out_valid_d;
  logic        ovr_q, ovr_d;

  logic        onehot;
  logic [1:0]  slot;
  logic [3:0]  nibble;
  logic        illegal;
  logic        accept;
  logic        ovr_set;
  logic [3:0]  cap_new;
  logic [15:0] frame_val;
  logic [3:0]  frame_err;

  seg7_glyph_decode u_decode (
    .seg_i     (seg_i),
    .nibble_o  (nibble),
    .illegal_o (illegal)
  );

  assign onehot = $onehot(dig_en_i);

  always_comb begin
    slot = 2'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_en_i[k]) slot = 2'(k);
    end
  end

  // The accepted latch limits each stable run to a single acceptance.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    accept = 1'b0;
    if (!onehot) begin
      cnt_d = 4'd0;
      acc_d = 1'b0;
    end else if ({dig_en_i, seg_i} != prev_q) begin
      cnt_d = 4'd1;
      acc_d = 1'b0;
    end else begin
      if (cnt_q < STABLE) cnt_d = cnt_q + 4'd1;
      if ((cnt_d == STABLE) && !acc_q) begin
        accept = 1'b1;
        acc_d  = 1'b1;
      end
    end
  end

  // The digit accepted this edge is bypassed into the frame so completion needs no extra cycle.
  always_comb begin
    cap_new   = cap_q | (4'b0001 << slot);
    frame_val = slot_val_q;
    frame_val[4*slot +: 4] = nibble;
    frame_err = slot_err_q;
    frame_err[slot] = illegal;

    cap_d       = cap_q;
    slot_val_d  = slot_val_q;
    slot_err_d  = slot_err_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    ovr_set     = 1'b0;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    if (accept) begin
      slot_val_d = frame_val;
      slot_err_d = frame_err;
      if (&cap_new) begin
        cap_d      = 4'd0;
        slot_err_d = 4'd0;
        if (!out_valid_q || out_ready_i) begin
          out_value_d = frame_val;
          out_err_d   = frame_err;
          out_valid_d = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
      end else begin
        cap_d = cap_new;
      end
    end

    if (ovr_set)        ovr_d = 1'b1;
    else if (ovr_clr_i) ovr_d = 1'b0;
    else                ovr_d = ovr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      cap_q       <= '0;
      slot_val_q  <= '0;
      slot_err_q  <= '0;
      out_value_q <= '0;
      out_err_q   <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      prev_q      <= {dig_en_i, seg_i};
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      cap_q       <= cap_d;
      slot_val_q  <= slot_val_d;
      slot_err_q  <= slot_err_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_value_o = out_value_q;
  assign out_err_o   = out_err_q;
  assign out_valid_o = out_valid_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Bench for seg7_frame_capture: directed scenarios plus random bus traffic against a run-length model.
module tb_seg7_frame_capture;

  localparam int STABLE = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [6:0]  seg_i;
  logic [3:0]  dig_en_i;
  logic [15:0] out_value_o;
  logic [3:0]  out_err_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        overrun_o;
  logic        ovr_clr_i;

  always #5 clk_i = ~clk_i;

  seg7_frame_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .seg_i       (seg_i),
    .dig_en_i    (dig_en_i),
    .out_value_o (out_value_o),
    .out_err_o   (out_err_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .overrun_o   (overrun_o),
    .ovr_clr_i   (ovr_clr_i)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: run length of the current identical sample and the digits gathered so far.
  bit          m_valid, m_ovr;
  logic [15:0] m_value;
  logic [3:0]  m_err;
  int          run_len;
  bit          have_last;
  logic [10:0] last;
  logic [3:0]  cap;
  logic [3:0]  sv [4];
  logic        se [4];
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_ovr = 0; m_value = '0; m_err = '0;
    run_len = 0; have_last = 0; last = '0; cap = '0;
    for (int i = 0; i < 4; i++) begin sv[i] = '0; se[i] = 1'b0; end
  endtask

  task automatic m_edge(input logic [3:0] d, input logic [6:0] s, input logic r, input logic c);
    int  k, nib;
    bit  bad, drop, was_valid, is_one;
    drop = 0;
    was_valid = m_valid;
    is_one = ($countones(d) == 1);
    if (!is_one) run_len = 0;
    else if (have_last && ({d, s} == last)) run_len++;
    else run_len = 1;
    last = {d, s};
    have_last = 1;
    if (was_valid && r) m_valid = 0;
    if (is_one && run_len == STABLE) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (d[i]) k = i;
      bad = 1; nib = 0;
      for (int i = 0; i < 16; i++) if (glyph[i] == s) begin bad = 0; nib = i; end
      sv[k] = 4'(nib); se[k] = bad; cap[k] = 1'b1;
      if (cap == 4'hF) begin
        if (!was_valid || r) begin
          m_value = {sv[3], sv[2], sv[1], sv[0]};
          m_err   = {se[3], se[2], se[1], se[0]};
          m_valid = 1;
        end else begin
          drop = 1;
        end
        cap = '0;
        for (int i = 0; i < 4; i++) se[i] = 1'b0;
      end
    end
    if (drop) m_ovr = 1;
    else if (c) m_ovr = 0;
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("out_valid", 32'(out_valid_o), 32'(m_valid));
      chk("overrun", 32'(overrun_o), 32'(m_ovr));
      if (m_valid) begin
        chk("out_value", 32'(out_value_o), 32'(m_value));
        chk("out_err", 32'(out_err_o), 32'(m_err));
      end
    end
  end

  task automatic step(input logic [3:0] d, input logic [6:0] s, input logic r, input logic c);
    dig_en_i = d; seg_i = s; out_ready_i = r; ovr_clr_i = c;
    @(posedge clk_i);
    if (rst_ni) m_edge(d, s, r, c);
    #1;
  endtask

  task automatic digit(input int k, input logic [6:0] s, input int n, input bit rdy_at_accept);
    for (int i = 0; i < n; i++)
      step(4'(1 << k), s, rdy_at_accept && (i == STABLE - 1), 1'b0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(4'b0000, 7'h7F, r, 1'b0);
  endtask

  initial begin
    int         len;
    logic [3:0] d;
    logic [6:0] s;

    // 1: reset with arbitrary inputs, then idle bus
    rst_ni = 1'b0;
    dig_en_i = 4'b0001; seg_i = 7'h30; out_ready_i = 1'b0; ovr_clr_i = 1'b1;
    m_reset();
    cmp_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_value", 32'(out_value_o), 32'h0000);
    chk("rst_err", 32'(out_err_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    rst_ni = 1'b1;
    idle(10, 1'b0);
    chk("idle_valid", 32'(out_valid_o), 32'd0);

    // 2: basic frame, valid rises on 4th edge of slot-0 run
    digit(3, 7'h12, 6, 0);
    digit(2, 7'h19, 6, 0);
    digit(1, 7'h30, 6, 0);
    digit(0, 7'h24, 3, 0);
    chk("t2_valid_early", 32'(out_valid_o), 32'd0);
    digit(0, 7'h24, 1, 0);
    chk("t2_valid", 32'(out_valid_o), 32'd1);
    chk("t2_value", 32'(out_value_o), 32'h5432);
    chk("t2_err", 32'(out_err_o), 32'd0);
    digit(0, 7'h24, 2, 0);

    // 3: a 3-cycle run is too short to be accepted
    idle(1, 1'b1);
    digit(3, 7'h78, 5, 0);
    digit(2, 7'h79, 5, 0);
    digit(1, 7'h79, 3, 0);
    digit(1, 7'h40, 4, 0);
    digit(0, 7'h79, 5, 0);
    chk("t3_value", 32'(out_value_o), 32'h7101);

    // 4: blank glyph flags an error
    idle(1, 1'b1);
    digit(3, 7'h0E, 5, 0);
    digit(2, 7'h7F, 5, 0);
    digit(1, 7'h21, 5, 0);
    digit(0, 7'h46, 5, 0);
    chk("t4_value", 32'(out_value_o), 32'hF0DC);
    chk("t4_err", 32'(out_err_o), 32'b0100);

    // 5: overrun, clear, completion with ready on the same edge
    idle(1, 1'b1);
    digit(3, 7'h79, 5, 0); digit(2, 7'h24, 5, 0); digit(1, 7'h30, 5, 0); digit(0, 7'h19, 5, 0);
    digit(3, 7'h12, 5, 0); digit(2, 7'h02, 5, 0); digit(1, 7'h78, 5, 0); digit(0, 7'h00, 5, 0);
    chk("t5_overrun", 32'(overrun_o), 32'd1);
    chk("t5_keepA", 32'(out_value_o), 32'h1234);
    step(4'b0000, 7'h7F, 1'b0, 1'b1);
    chk("t5_clr", 32'(overrun_o), 32'd0);
    digit(3, 7'h10, 5, 0); digit(2, 7'h08, 5, 0); digit(1, 7'h03, 5, 0); digit(0, 7'h46, STABLE, 1);
    chk("t5_valid", 32'(out_valid_o), 32'd1);
    chk("t5_valueC", 32'(out_value_o), 32'h9ABC);
    chk("t5_ovr_stays", 32'(overrun_o), 32'd0);

    // 6: reset mid-frame discards captured slots
    idle(1, 1'b1);
    digit(3, 7'h78, 5, 0);
    digit(2, 7'h08, 5, 0);
    rst_ni = 1'b0;
    m_reset();
    step(4'b0000, 7'h7F, 1'b0, 1'b0);
    rst_ni = 1'b1;
    digit(1, 7'h03, 5, 0);
    digit(0, 7'h46, 5, 0);
    chk("t6_no_early", 32'(out_valid_o), 32'd0);
    digit(3, 7'h78, 5, 0);
    digit(2, 7'h08, 5, 0);
    chk("t6_value", 32'(out_value_o), 32'h7ABC);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 9) == 0) d = 4'($urandom);
      else d = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) s = 7'($urandom);
      else s = glyph[$urandom_range(0, 15)];
      for (int i = 0; i < len; i++)
        step(d, s, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(3, 1'b1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
